// File: rtl/fdivsqrt_arbiter_pkg.sv
// Shared types for the divide/sqrt datapath arbiter: FSM state encoding and watchdog slack.
package fdivsqrt_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RUN  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    // Extra cycles the datapath may take beyond its nominal iteration count.
    localparam int WDOG_SLACK = 2;

endpackage

// File: rtl/fdivsqrt_rrpick.sv
// Two-requester picker. FDIVSQRT_ARB_RR_EN selects round-robin; otherwise FP has fixed priority.
module fdivsqrt_rrpick
    import fdivsqrt_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic allow_i,
    input  logic f_req_i,
    input  logic i_req_i,
    output logic f_gnt_o,
    output logic i_gnt_o
);

`ifdef FDIVSQRT_ARB_RR_EN
    logic last_int_q, last_int_d;

    // On a tie, serve whoever was not served last.
    assign f_gnt_o = allow_i & f_req_i & (~i_req_i | last_int_q);
    assign i_gnt_o = allow_i & i_req_i & (~f_req_i | ~last_int_q);

    always_comb begin
        last_int_d = last_int_q;
        if (f_gnt_o | i_gnt_o) last_int_d = i_gnt_o;
    end

    always_ff @(posedge clk) begin
        if (reset) last_int_q <= 1'b0;
        else       last_int_q <= last_int_d;
    end
`else
    logic unused_rr;
    assign unused_rr = clk | reset;

    assign f_gnt_o = allow_i & f_req_i;
    assign i_gnt_o = allow_i & i_req_i & ~f_req_i;
`endif

endmodule

// File: rtl/fdivsqrt_arbiter.sv
// Arbiter sharing the iterative div/sqrt datapath between FP and integer requesters.
// Arbitration policy is set by FDIVSQRT_ARB_RR_EN (round-robin) or fixed FP priority when undefined.
module fdivsqrt_arbiter
    import fdivsqrt_arbiter_pkg::*;
#(
    parameter int TAGW   = 5,
    parameter int DURLEN = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              FReqE,
    input  logic [TAGW-1:0]   FTagE,
    input  logic [DURLEN-1:0] FCyclesE,
    input  logic              IReqE,
    input  logic [TAGW-1:0]   ITagE,
    input  logic [DURLEN-1:0] ICyclesE,
    input  logic              FlushE,
    input  logic              StallM,
    input  logic              UnitDoneE,
    output logic              FGntE,
    output logic              IGntE,
    output logic              UnitStartE,
    output logic              UnitIntE,
    output logic [DURLEN-1:0] UnitCyclesE,
    output logic              BusyE,
    output logic              FDoneM,
    output logic              IDoneM,
    output logic [TAGW-1:0]   DoneTagM,
    output logic              TimeoutM
);

    arb_state_e        state_q, state_d;
    logic              int_q, int_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic [DURLEN-1:0] cyc_q, cyc_d;
    logic [DURLEN:0]   wd_q, wd_d;
    logic              tmo_q, tmo_d;
    logic              allow, any_gnt;

    assign allow = (state_q == ARB_IDLE) & ~StallM & ~FlushE & ~reset;

    fdivsqrt_rrpick u_pick (
        .clk     (clk),
        .reset   (reset),
        .allow_i (allow),
        .f_req_i (FReqE),
        .i_req_i (IReqE),
        .f_gnt_o (FGntE),
        .i_gnt_o (IGntE)
    );

    assign any_gnt     = FGntE | IGntE;
    assign UnitStartE  = any_gnt;
    assign UnitCyclesE = any_gnt ? (IGntE ? ICyclesE : FCyclesE) : cyc_q;
    assign UnitIntE    = (state_q == ARB_IDLE) ? IGntE : int_q;
    assign BusyE       = (state_q != ARB_IDLE) | any_gnt;
    assign FDoneM      = (state_q == ARB_RESP) & ~int_q;
    assign IDoneM      = (state_q == ARB_RESP) & int_q;
    assign DoneTagM    = (state_q == ARB_RESP) ? tag_q : '0;
    assign TimeoutM    = tmo_q;

    always_comb begin
        state_d = state_q;
        int_d   = int_q;
        tag_d   = tag_q;
        cyc_d   = cyc_q;
        wd_d    = wd_q;
        tmo_d   = tmo_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_gnt) begin
                    state_d = ARB_RUN;
                    int_d   = IGntE;
                    tag_d   = IGntE ? ITagE : FTagE;
                    cyc_d   = UnitCyclesE;
                    wd_d    = {1'b0, UnitCyclesE} + (DURLEN+1)'(WDOG_SLACK);
                end
            end
            ARB_RUN: begin
                // Flush wins over a coincident done; the result is dropped.
                if (FlushE) begin
                    state_d = ARB_IDLE;
                    int_d   = 1'b0;
                end else if (UnitDoneE) begin
                    state_d = ARB_RESP;
                end else if (wd_q <= (DURLEN+1)'(1)) begin
                    state_d = ARB_IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    wd_d = wd_q - (DURLEN+1)'(1);
                end
            end
            ARB_RESP: begin
                if (~StallM) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            int_q   <= 1'b0;
            tag_q   <= '0;
            cyc_q   <= '0;
            wd_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            tag_q   <= tag_d;
            cyc_q   <= cyc_d;
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_fdivsqrt_arbiter.sv
// Directed self-checking bench for fdivsqrt_arbiter; expectations follow FDIVSQRT_ARB_RR_EN.
module tb_fdivsqrt_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       FReqE, IReqE, FlushE, StallM, UnitDoneE;
    logic [4:0] FTagE, ITagE;
    logic [5:0] FCyclesE, ICyclesE;
    logic       FGntE, IGntE, UnitStartE, UnitIntE, BusyE, FDoneM, IDoneM, TimeoutM;
    logic [5:0] UnitCyclesE;
    logic [4:0] DoneTagM;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_f_order;

    always #5 clk = ~clk;

    fdivsqrt_arbiter #(.TAGW(5), .DURLEN(6)) dut (
        .clk(clk), .reset(reset),
        .FReqE(FReqE), .FTagE(FTagE), .FCyclesE(FCyclesE),
        .IReqE(IReqE), .ITagE(ITagE), .ICyclesE(ICyclesE),
        .FlushE(FlushE), .StallM(StallM), .UnitDoneE(UnitDoneE),
        .FGntE(FGntE), .IGntE(IGntE), .UnitStartE(UnitStartE), .UnitIntE(UnitIntE),
        .UnitCyclesE(UnitCyclesE), .BusyE(BusyE), .FDoneM(FDoneM), .IDoneM(IDoneM),
        .DoneTagM(DoneTagM), .TimeoutM(TimeoutM)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; inputs are driven there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
`ifdef FDIVSQRT_ARB_RR_EN
        exp_f_order = 3'b101;
`else
        exp_f_order = 3'b111;
`endif
        reset = 1'b1;
        FReqE = 0; IReqE = 0; FlushE = 0; StallM = 0; UnitDoneE = 0;
        FTagE = 0; ITagE = 0; FCyclesE = 0; ICyclesE = 0;
        step(); step();
        settle();
        chk("rst_fdone", FDoneM, 0);
        chk("rst_idone", IDoneM, 0);
        chk("rst_tag", DoneTagM, 0);
        chk("rst_tmo", TimeoutM, 0);
        chk("rst_busy", BusyE, 0);
        chk("rst_cycles", UnitCyclesE, 0);
        step();
        reset = 1'b0;

        // FP op, 10 iterations, tag 3
        FReqE = 1; FTagE = 3; FCyclesE = 10;
        settle();
        chk("t1_fgnt", FGntE, 1);
        chk("t1_ignt", IGntE, 0);
        chk("t1_start", UnitStartE, 1);
        chk("t1_cycles", UnitCyclesE, 10);
        chk("t1_int", UnitIntE, 0);
        chk("t1_busy", BusyE, 1);
        step();
        FReqE = 0; FCyclesE = 0;
        settle();
        chk("t1_run_cycles", UnitCyclesE, 10);
        chk("t1_run_start", UnitStartE, 0);
        for (int c = 2; c <= 10; c++) step();
        UnitDoneE = 1;
        settle();
        chk("t1_nodone_yet", FDoneM, 0);
        step();
        UnitDoneE = 0;
        settle();
        chk("t1_fdone", FDoneM, 1);
        chk("t1_idone", IDoneM, 0);
        chk("t1_tag", DoneTagM, 3);
        step();
        settle();
        chk("t1_fdone_off", FDoneM, 0);
        chk("t1_idle", BusyE, 0);

        // Integer op held in RESP by a 4-cycle stall
        IReqE = 1; ITagE = 7; ICyclesE = 2;
        settle();
        chk("t2_ignt", IGntE, 1);
        chk("t2_fgnt", FGntE, 0);
        chk("t2_int", UnitIntE, 1);
        step();
        IReqE = 0;
        settle();
        chk("t2_int_run", UnitIntE, 1);
        step();
        UnitDoneE = 1;
        step();
        UnitDoneE = 0; StallM = 1;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) StallM = 0;
            settle();
            chk("t2_idone_hold", IDoneM, 1);
            chk("t2_tag_hold", DoneTagM, 7);
            step();
        end
        settle();
        chk("t2_idone_off", IDoneM, 0);
        chk("t2_idle", BusyE, 0);

        // Simultaneous requests across three operations
        FReqE = 1; IReqE = 1; FTagE = 1; ITagE = 2; FCyclesE = 3; ICyclesE = 5;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t3_fgnt", FGntE, exp_f_order[2-k]);
            chk("t3_ignt", IGntE, !exp_f_order[2-k]);
            chk("t3_cycles", UnitCyclesE, exp_f_order[2-k] ? 3 : 5);
            step();
            settle();
            chk("t3_no_gnt_run", FGntE | IGntE, 0);
            step();
            UnitDoneE = 1;
            step();
            UnitDoneE = 0;
            settle();
            chk("t3_fdone", FDoneM, exp_f_order[2-k]);
            chk("t3_idone", IDoneM, !exp_f_order[2-k]);
            chk("t3_tag", DoneTagM, exp_f_order[2-k] ? 1 : 2);
            step();
        end
        FReqE = 0; IReqE = 0;

        // Request blocked by StallM in IDLE, granted the cycle it drops
        StallM = 1; FReqE = 1; FTagE = 4; FCyclesE = 3;
        settle();
        chk("t4_stall_gnt0", FGntE, 0);
        chk("t4_stall_busy0", BusyE, 0);
        step();
        settle();
        chk("t4_stall_gnt1", FGntE, 0);
        step();
        StallM = 0;
        settle();
        chk("t4_gnt", FGntE, 1);
        step();
        FReqE = 0;

        // Flush on the 3rd RUN cycle, late done ignored, next request granted
        step();
        step();
        FlushE = 1;
        step();
        FlushE = 0;
        settle();
        chk("t5_flush_idle", BusyE, 0);
        step();
        UnitDoneE = 1;
        step();
        UnitDoneE = 0;
        settle();
        chk("t5_no_fdone", FDoneM, 0);
        chk("t5_no_idone", IDoneM, 0);

        // Integer op with no done: watchdog of 4+2
        IReqE = 1; ITagE = 9; ICyclesE = 4;
        settle();
        chk("t6_ignt", IGntE, 1);
        step();
        IReqE = 0;
        for (int c = 1; c <= 6; c++) begin
            settle();
            chk("t6_tmo_low", TimeoutM, 0);
            chk("t6_busy_run", BusyE, 1);
            step();
        end
        settle();
        chk("t6_tmo_set", TimeoutM, 1);
        chk("t6_idle", BusyE, 0);
        chk("t6_no_done", IDoneM, 0);
        step(); step(); step();
        settle();
        chk("t6_tmo_sticky", TimeoutM, 1);

        // Reset mid-RUN: next cycle IDLE, no done, watchdog flag cleared
        FReqE = 1; FTagE = 5; FCyclesE = 2;
        step();
        FReqE = 0;
        step();
        reset = 1; UnitDoneE = 1;
        step();
        UnitDoneE = 0;
        settle();
        chk("t7_rst_busy", BusyE, 0);
        chk("t7_rst_fdone", FDoneM, 0);
        chk("t7_rst_tmo", TimeoutM, 0);
        reset = 0;
        step();
        settle();
        chk("t7_post_fdone", FDoneM, 0);
        chk("t7_post_busy", BusyE, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
